// File: rtl/router_pkg.sv
// router_pkg: shared state encoding, header layout constants and the header
// packing helper for the router packet transmitter.
package router_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP} state_t;
   localparam int HDR_LEN_MSB = 7;
   localparam int HDR_LEN_LSB = 2;
   localparam int ADDR_W = 2;
   localparam int MAX_LEN = 63;
   localparam int NUM_PORTS = 3;
   localparam logic [7:0] PARITY_CORRUPT_MASK = 8'h01;
   function automatic logic [7:0] make_hdr(input logic [HDR_LEN_MSB-HDR_LEN_LSB:0] len,
                                           input logic [ADDR_W-1:0] addr);
      return {len, addr};
   endfunction
endpackage

// File: rtl/router_tx_buf.sv
// router_tx_buf: payload staging register file, synchronous write and
// combinational read.
module router_tx_buf import router_pkg::*; (
   input  logic       i_clk,
   input  logic       i_we,
   input  logic [5:0] i_waddr,
   input  logic [7:0] i_wdata,
   input  logic [5:0] i_raddr,
   output logic [7:0] o_rdata
);
   logic [7:0] r_mem [MAX_LEN];
   always_ff @(posedge i_clk)
      if (i_we) r_mem[i_waddr] <= i_wdata;
   // The look-ahead read can point one past the last entry; that value is never used.
   assign o_rdata = (i_raddr < 6'(MAX_LEN)) ? r_mem[i_raddr] : '0;
endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers a full payload, then drives header, payload and
// parity onto the router input pins while honouring busy back-pressure.
module router_pkt_tx import router_pkg::*; #(
   parameter int GAP_CYCLES = 2
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [5:0]        cmd_len,
   input  logic              cmd_corrupt,
   output logic              cmd_err,
   input  logic              pl_valid,
   input  logic [7:0]        pl_data,
   output logic              pl_ready,
   input  logic              busy,
   output logic              pkt_valid,
   output logic [7:0]        data_out,
   output logic              done
);
   state_t            r_state, w_state;
   logic [ADDR_W-1:0] r_addr, w_addr;
   logic [5:0]        r_len, w_len, r_cnt, w_cnt;
   logic              r_corrupt, w_corrupt, r_pkt_valid, w_pkt_valid;
   logic              r_done, w_done, r_cmd_err, w_cmd_err, w_we;
   logic [7:0]        r_par, w_par, r_data, w_data, w_rdata;
   logic [3:0]        r_gap, w_gap;
   router_tx_buf u_buf (
      .i_clk   (clock),
      .i_we    (w_we),
      .i_waddr (r_cnt),
      .i_wdata (pl_data),
      .i_raddr (r_cnt + 6'(r_state == PAYLOAD)),
      .o_rdata (w_rdata)
   );
   assign cmd_ready = r_state == IDLE;
   assign pl_ready  = r_state == LOAD;
   assign pkt_valid = r_pkt_valid;
   assign data_out  = r_data;
   assign done      = r_done;
   assign cmd_err   = r_cmd_err;
   always_comb begin
      w_state     = r_state;
      w_addr      = r_addr;
      w_len       = r_len;
      w_corrupt   = r_corrupt;
      w_cnt       = r_cnt;
      w_par       = r_par;
      w_data      = r_data;
      w_pkt_valid = r_pkt_valid;
      w_gap       = r_gap;
      w_done      = 1'b0;
      w_cmd_err   = 1'b0;
      w_we        = 1'b0;
      case (r_state)
         IDLE:
            if (cmd_valid) begin
               if (cmd_len == '0 || cmd_addr >= ADDR_W'(NUM_PORTS)) w_cmd_err = 1'b1;
               else begin
                  w_addr    = cmd_addr;
                  w_len     = cmd_len;
                  w_corrupt = cmd_corrupt;
                  w_cnt     = '0;
                  w_par     = make_hdr(cmd_len, cmd_addr);
                  w_state   = LOAD;
               end
            end
         LOAD:
            if (pl_valid) begin
               w_we  = 1'b1;
               w_par = r_par ^ pl_data;
               w_cnt = r_cnt + 6'd1;
               if (r_cnt == r_len - 6'd1) begin
                  w_data      = make_hdr(r_len, r_addr);
                  w_pkt_valid = 1'b1;
                  w_cnt       = '0;
                  w_state     = HEADER;
               end
            end
         HEADER:
            if (!busy) begin
               w_data  = w_rdata;
               w_state = PAYLOAD;
            end
         PAYLOAD:
            if (!busy) begin
               if (r_cnt < r_len - 6'd1) begin
                  w_data = w_rdata;
                  w_cnt  = r_cnt + 6'd1;
               end else begin
                  w_data      = r_par ^ (r_corrupt ? PARITY_CORRUPT_MASK : 8'h00);
                  w_pkt_valid = 1'b0;
                  w_state     = PARITY;
               end
            end
         PARITY:
            if (!busy) begin
               w_data  = '0;
               w_done  = 1'b1;
               w_gap   = 4'(GAP_CYCLES - 1);
               w_state = GAP;
            end
         GAP: begin
            w_gap   = r_gap - 4'd1;
            w_state = r_gap == '0 ? IDLE : GAP;
         end
         default: w_state = IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_len       <= '0;
         r_corrupt   <= 1'b0;
         r_cnt       <= '0;
         r_par       <= '0;
         r_data      <= '0;
         r_pkt_valid <= 1'b0;
         r_gap       <= '0;
         r_done      <= 1'b0;
         r_cmd_err   <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_addr      <= w_addr;
         r_len       <= w_len;
         r_corrupt   <= w_corrupt;
         r_cnt       <= w_cnt;
         r_par       <= w_par;
         r_data      <= w_data;
         r_pkt_valid <= w_pkt_valid;
         r_gap       <= w_gap;
         r_done      <= w_done;
         r_cmd_err   <= w_cmd_err;
      end
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: directed packet table plus hand sequences for illegal
// commands and an asynchronous reset in the middle of a packet.
module tb_router_pkt_tx;
   logic       clock = 1'b0, resetn = 1'b1, cmd_valid = 1'b0, cmd_corrupt = 1'b0;
   logic       pl_valid = 1'b0, busy = 1'b0;
   logic [1:0] cmd_addr = '0;
   logic [5:0] cmd_len = '0;
   logic [7:0] pl_data = '0;
   logic       cmd_ready, cmd_err, pl_ready, pkt_valid, done;
   logic [7:0] data_out;
   int         checks = 0, errors = 0;
   typedef struct {
      logic [1:0] addr;
      logic [5:0] len;
      logic       corrupt;
      logic [7:0] base, step;
      logic       toggle;
      int         busy_pos, busy_n;
      logic [7:0] hdr, par;
   } vec_t;
   vec_t tbl[5];
   router_pkt_tx #(.GAP_CYCLES(2)) dut (
      .clock(clock), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_corrupt(cmd_corrupt), .cmd_err(cmd_err),
      .pl_valid(pl_valid), .pl_data(pl_data), .pl_ready(pl_ready), .busy(busy),
      .pkt_valid(pkt_valid), .data_out(data_out), .done(done)
   );
   always #5 clock = ~clock;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic run_pkt(input vec_t v, input int stop);
      int cyc, idx, pos, bcnt;
      logic acc;
      logic [7:0] exp;
      cyc = 0;
      while (!cmd_ready && cyc < 200) begin
         @(posedge clock); #1; cyc++;
      end
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_addr = v.addr; cmd_len = v.len; cmd_corrupt = v.corrupt;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      chk("pl_ready_rise", {cmd_ready, pl_ready}, 2'b01);
      idx = 0; cyc = 0;
      while (idx < int'(v.len) && cyc < 300) begin
         pl_valid = !v.toggle || cyc % 2 == 0;
         pl_data  = 8'(v.base + v.step * idx);
         acc      = pl_valid && pl_ready;
         @(posedge clock); #1; cyc++;
         if (acc) idx++;
      end
      pl_valid = 1'b0;
      chk("load_cycles", cyc, v.toggle ? 2 * v.len - 1 : 32'(v.len));
      pos = 0; bcnt = 0; cyc = 0;
      while (pos < stop && cyc < 400) begin
         exp = pos == 0 ? v.hdr : pos <= int'(v.len) ? 8'(v.base + v.step * (pos - 1)) : v.par;
         chk($sformatf("byte%0d", pos), {done, pkt_valid, data_out}, {1'b0, pos <= int'(v.len), exp});
         busy = pos == v.busy_pos && bcnt < v.busy_n;
         if (busy) bcnt++;
         @(posedge clock); #1; cyc++;
         if (!busy) pos++;
      end
      busy = 1'b0;
      if (stop < int'(v.len) + 2) return;
      chk("pkt_cycles", cyc, v.len + 2 + v.busy_n);
      chk("done_pulse", {done, cmd_ready, pkt_valid, data_out}, {1'b1, 1'b0, 1'b0, 8'h00});
      for (int g = 1; g <= 2; g++) begin
         @(posedge clock); #1;
         chk("gap", {done, cmd_ready, pkt_valid}, g == 2 ? 3'b010 : 3'b000);
      end
   endtask
   initial begin
      tbl[0] = '{2'd1, 6'd3,  1'b0, 8'hA1, 8'h11, 1'b0, -1, 0, 8'h0D, 8'hDD};
      tbl[1] = '{2'd1, 6'd3,  1'b1, 8'hA1, 8'h11, 1'b0, -1, 0, 8'h0D, 8'hDC};
      tbl[2] = '{2'd1, 6'd3,  1'b0, 8'hA1, 8'h11, 1'b0,  2, 3, 8'h0D, 8'hDD};
      tbl[3] = '{2'd2, 6'd63, 1'b0, 8'h00, 8'h01, 1'b1, -1, 0, 8'hFE, 8'hC1};
      tbl[4] = '{2'd0, 6'd1,  1'b0, 8'h5A, 8'h00, 1'b0, -1, 0, 8'h04, 8'h5E};
      #2 resetn = 1'b0;
      #1 chk("reset_values", {cmd_ready, pl_ready, pkt_valid, data_out, done, cmd_err},
             {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
      #20 resetn = 1'b1;
      @(posedge clock); #1;
      for (int i = 0; i < 4; i++) run_pkt(tbl[i], int'(tbl[i].len) + 2);
      for (int i = 0; i < 2; i++) begin
         cmd_valid = 1'b1;
         cmd_addr  = i == 0 ? 2'd1 : 2'd3;
         cmd_len   = i == 0 ? 6'd0 : 6'd5;
         @(posedge clock); #1;
         cmd_valid = 1'b0;
         chk("cmd_err_pulse", {cmd_err, cmd_ready, pl_ready, pkt_valid}, 4'b1100);
         @(posedge clock); #1;
         chk("cmd_err_clear", {cmd_err, cmd_ready, pl_ready, pkt_valid}, 4'b0100);
      end
      run_pkt(tbl[0], 3);
      #3 resetn = 1'b0;
      #1 chk("async_reset", {cmd_ready, pl_ready, pkt_valid, data_out, done},
             {1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
      #3 resetn = 1'b1;
      run_pkt(tbl[4], int'(tbl[4].len) + 2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet transmitter for the 1x3 router protocol: drives the router's `pkt_valid`/`data_in` pins with well-formed packets (header, 1–63 payload bytes, parity) and honours the router's `busy` back-pressure. It accepts a transmit command and then buffers the full payload from an upstream valid/ready stream. Only after the payload is buffered does it start a packet, so `pkt_valid` is never dropped mid-payload for lack of data. It is the stimulus and source end of the link whose receive side checks parity and flags `err`.

## Interface
- `GAP_CYCLES`, 2: idle cycles (pkt_valid=0, data_out=0) after each packet's parity byte before the next command is accepted; legal range 1–15.
- `clock`  in  1  single clock, rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_addr`  in  2  destination port; 0–2 legal.
- `cmd_len`  in  6  payload length; 1–63 legal.
- `cmd_corrupt`  in  1  when set, the transmitted parity is deliberately wrong (XOR 8'h01).
- `cmd_err`  out  1  one-cycle pulse when an illegal command is rejected.
- `pl_valid`  in  1  upstream payload byte valid.
- `pl_data`  in  8  payload byte.
- `pl_ready`  out  1  high only in LOAD.
- `busy`  in  1  router back-pressure; while high, the current output byte is held.
- `pkt_valid`  out  1  registered; high during header and payload, low during parity.
- `data_out`  out  8  registered byte to the router `data_in`.
- `done`  out  1  one-cycle pulse on the edge that retires the parity byte.

## Operation
- Header byte = {len[5:0], addr[1:0]}.
- Parity = header XOR all payload bytes, then XOR 8'h01 if corrupt was latched.
- A byte on `data_out` is consumed at a rising edge where `busy`=0. While `busy`=1, `data_out` and `pkt_valid` hold their values.
- States:
  - IDLE: `cmd_ready`=1. On `cmd_valid`:
    - `cmd_len`=0 or `cmd_addr`=3: pulse `cmd_err` next cycle and stay in IDLE.
    - Otherwise: latch addr, len and corrupt; clear the byte counter; set the running parity to the header value; go to LOAD.
  - LOAD: `pl_ready`=1. Each `pl_valid`&`pl_ready` beat writes `buf[cnt]`, XORs the byte into the running parity and increments `cnt`. On the edge accepting beat len-1: load `data_out`<=header, `pkt_valid`<=1, clear `cnt`, go to HEADER. `pl_valid` gaps simply stall LOAD.
  - HEADER: on consume, `data_out`<=`buf[0]`, go to PAYLOAD.
  - PAYLOAD: on consume of byte `cnt`:
    - if `cnt`<len-1: `data_out`<=`buf[cnt+1]`, `cnt`++.
    - else: `data_out`<=parity, `pkt_valid`<=0, go to PARITY.
  - PARITY: on consume, `data_out`<=0, pulse `done`, load the gap counter, go to GAP.
  - GAP: count `GAP_CYCLES` cycles, then go to IDLE.
- `cmd_valid` outside IDLE is ignored. Commands are not queued.
- Reset asserted mid-operation aborts the packet immediately. The router sees `pkt_valid` fall with no parity byte; recovery is the router's responsibility.

## Timing
- Reset values: `pkt_valid`=0, `data_out`=0, `done`=0, `cmd_err`=0, `pl_ready`=0, `cmd_ready`=1 (state IDLE). Counters and parity are cleared; buffer contents are don't-care.
- Command accepted at edge T → `pl_ready` high from T+1.
- With `pl_valid` continuous: the last beat is at edge T+len, and the header is on `data_out` after that edge.
- With `busy`=0 throughout, the len+2 packet bytes occupy len+2 consecutive cycles. `done` is high in the cycle after the parity byte's consume edge.
- Next `cmd_ready` comes `GAP_CYCLES` cycles after `done`.
- `busy` stalls extend the current byte one cycle per busy cycle, with no byte loss or duplication.

## Structure
- Shared package `router_pkg` holds:
  - state enum {IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP};
  - `HDR_LEN_MSB`=7, `HDR_LEN_LSB`=2, `ADDR_W`=2, `MAX_LEN`=63, `NUM_PORTS`=3;
  - `PARITY_CORRUPT_MASK`=8'h01.
- Sub-module `router_tx_buf`: 63x8 register file, synchronous write, combinational read, no reset.

## Test plan
- addr=1, len=3, payload A1,B2,C3, busy=0 → `data_out` sequence 0D, A1, B2, C3, DD; `pkt_valid` 1,1,1,1,0; `done` pulses once.
- Same packet with `cmd_corrupt`=1 → parity byte DC; all other bytes unchanged.
- Same packet with `busy` high for 3 cycles during byte B2 → B2 held 4 cycles with `pkt_valid`=1; sequence otherwise identical and nothing duplicated.
- `cmd_len`=0, then `cmd_addr`=3 with len=5 → each gives a single `cmd_err` pulse, `pl_ready` never rises and `pkt_valid` stays 0.
- addr=2, len=63 with payload 00..3E and `pl_valid` toggling 1/0 → header FE, 63 payload bytes in order, parity = FE XOR (XOR of 00..3E).
- `resetn` pulsed low while PAYLOAD is on byte 2 → `pkt_valid` and `data_out` go to 0 asynchronously and `cmd_ready`=1; a following len=1 packet transmits correctly.
